// File: rtl/imem_pkg.sv
// ============================================================================
// imem_pkg : shared types and constants for the loadable instruction memory
// Rev 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } imem_state_t;

    localparam logic [63:0] NOP_INSTR = '0;

    typedef struct packed {
        logic misaligned;
        logic out_of_range;
        logic unloaded;
    } imem_fault_t;

endpackage

`default_nettype wire

// File: rtl/imem_ram.sv
// ============================================================================
// imem_ram : single-write, synchronous-read RAM without reset
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_ram
    import imem_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : loadable LEGv8 instruction memory with registered fetch port
// Rev 1.0 -- optional fault reporting enabled by defining IMEM_FAULT_EN
// ============================================================================
`default_nettype none

module imem_loader
    import imem_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [N-1:0]  ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          reload,
    input  logic          req_valid,
    input  logic [63:0]   req_pc,
    output logic          req_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_instr,
    output logic          rsp_fault,
    input  logic          flush,
    output logic          loaded,
    output logic [AW:0]   count
);

    imem_state_t   state;
    logic          rsp_zero;
    logic [N-1:0]  ram_rdata;
    logic [AW-1:0] rd_idx;
    logic          unloaded;
    logic          ld_fire;
    logic          req_fire;
    logic          nxt_zero;
    logic          nxt_fault;

    assign ld_ready  = (state == S_LOAD);
    assign loaded    = (state == S_RUN);
    assign req_ready = (state == S_RUN) && !flush && (!rsp_valid || rsp_ready);
    assign ld_fire   = ld_valid && ld_ready;
    assign req_fire  = req_valid && req_ready;
    assign rd_idx    = req_pc[AW+1:2];
    assign unloaded  = ({1'b0, rd_idx} >= count);

`ifdef IMEM_FAULT_EN
    imem_fault_t why;
    assign why = '{misaligned:   (req_pc[1:0] != 2'b00),
                   out_of_range: (req_pc[63:AW+2] != '0),
                   unloaded:     unloaded};
    assign nxt_fault = |why;
    assign nxt_zero  = |why;
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^{req_pc[63:AW+2], req_pc[1:0]};
    assign nxt_fault = 1'b0;
    assign nxt_zero  = unloaded;
`endif

    imem_ram #(.N(N), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ld_fire && !reload),
        .waddr (count[AW-1:0]),
        .wdata (ld_data),
        .re    (req_fire && !reload),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    // RAM output carries no reset, so a registered flag forces the response to NOP
    assign rsp_instr = rsp_zero ? N'(NOP_INSTR) : ram_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_LOAD;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_zero  <= 1'b1;
            rsp_fault <= 1'b0;
        end else if (reload) begin
            state     <= S_LOAD;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_zero  <= 1'b1;
            rsp_fault <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (ld_fire) begin
                        count <= count + 1'b1;
                        if (ld_last || (count == (AW+1)'(DEPTH-1))) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (req_fire) begin
                        rsp_valid <= 1'b1;
                        rsp_zero  <= nxt_zero;
                        rsp_fault <= nxt_fault;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= S_LOAD;
            endcase
            if (flush) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : directed self-checking bench for imem_loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int N     = 32;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ld_valid = 1'b0;
    logic [N-1:0]  ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          reload = 1'b0;
    logic          req_valid = 1'b0;
    logic [63:0]   req_pc = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [N-1:0]  rsp_instr;
    logic          rsp_fault;
    logic          flush = 1'b0;
    logic          loaded;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    imem_loader #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .reload    (reload),
        .req_valid (req_valid),
        .req_pc    (req_pc),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .loaded    (loaded),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [N-1:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch_one(input string tag, input logic [63:0] pc,
                             input logic [N-1:0] exp_instr, input logic exp_fault);
        req_valid = 1'b1;
        req_pc    = pc;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        check_eq({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check_eq({tag, "_instr"}, 64'(rsp_instr), 64'(exp_instr));
        check_eq({tag, "_fault"}, 64'(rsp_fault), 64'(exp_fault));
    endtask

    logic [N-1:0] prog [5] = '{32'hf8000001, 32'hf8008002, 32'hf8000203,
                               32'h8b050083, 32'hf8018003};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_ldready", 64'(ld_ready), 64'd1);
        check_eq("rst_rspvalid", 64'(rsp_valid), 64'd0);
        check_eq("rst_instr", 64'(rsp_instr), 64'd0);
        reset = 1'b1;
        tick();
        check_eq("rst_loaded", 64'(loaded), 64'd0);
        check_eq("rst_reqready", 64'(req_ready), 64'd0);

        // basic program load
        for (int i = 0; i < 5; i++) begin
            load_word(prog[i], i == 4);
            if (i == 3) check_eq("load_mid_loaded", 64'(loaded), 64'd0);
        end
        check_eq("load_count", 64'(count), 64'd5);
        check_eq("load_loaded", 64'(loaded), 64'd1);
        check_eq("load_ldready", 64'(ld_ready), 64'd0);

        // back-to-back fetch
        req_valid = 1'b1;
        req_pc    = 64'h0C;
        rsp_ready = 1'b1;
        #1;
        check_eq("b2b_reqready0", 64'(req_ready), 64'd1);
        tick();
        check_eq("b2b_instr0", 64'(rsp_instr), 64'h8b050083);
        check_eq("b2b_fault0", 64'(rsp_fault), 64'd0);
        req_pc = 64'h10;
        #1;
        check_eq("b2b_reqready1", 64'(req_ready), 64'd1);
        tick();
        check_eq("b2b_valid1", 64'(rsp_valid), 64'd1);
        check_eq("b2b_instr1", 64'(rsp_instr), 64'hf8018003);
        req_valid = 1'b0;
        tick();
        check_eq("b2b_drain", 64'(rsp_valid), 64'd0);

        // back-pressure
        req_valid = 1'b1;
        req_pc    = 64'h00;
        rsp_ready = 1'b0;
        tick();
        req_pc = 64'h04;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bp_reqready", 64'(req_ready), 64'd0);
            check_eq("bp_instr", 64'(rsp_instr), 64'hf8000001);
            check_eq("bp_valid", 64'(rsp_valid), 64'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check_eq("bp_next_instr", 64'(rsp_instr), 64'hf8008002);
        tick();
        check_eq("bp_no_dup", 64'(rsp_valid), 64'd0);

        // illegal / unusual addresses
`ifdef IMEM_FAULT_EN
        fetch_one("unloaded", 64'h14, 32'h0, 1'b1);
        fetch_one("misalign", 64'h02, 32'h0, 1'b1);
        fetch_one("oor", 64'h100, 32'h0, 1'b1);
`else
        fetch_one("unloaded", 64'h14, 32'h0, 1'b0);
        fetch_one("misalign", 64'h02, 32'hf8000001, 1'b0);
        fetch_one("wrap", 64'h100, 32'hf8000001, 1'b0);
`endif
        fetch_one("after_fault", 64'h08, 32'hf8000203, 1'b0);
        tick();

        // flush with a pending response
        req_valid = 1'b1;
        req_pc    = 64'h08;
        rsp_ready = 1'b0;
        tick();
        check_eq("flush_pending", 64'(rsp_valid), 64'd1);
        flush = 1'b1;
        #1;
        check_eq("flush_reqready", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        check_eq("flush_valid", 64'(rsp_valid), 64'd0);

        // reload during a fetch
        req_valid = 1'b1;
        req_pc    = 64'h00;
        rsp_ready = 1'b1;
        reload    = 1'b1;
        tick();
        reload    = 1'b0;
        req_valid = 1'b0;
        check_eq("reload_loaded", 64'(loaded), 64'd0);
        check_eq("reload_count", 64'(count), 64'd0);
        check_eq("reload_valid", 64'(rsp_valid), 64'd0);

        // full load without ld_last
        for (int i = 0; i < DEPTH; i++) begin
            load_word(32'h1000_0000 + 32'(i), 1'b0);
            if (i == DEPTH - 2) check_eq("full_63_loaded", 64'(loaded), 64'd0);
        end
        check_eq("full_count", 64'(count), 64'd64);
        check_eq("full_loaded", 64'(loaded), 64'd1);
        check_eq("full_ldready", 64'(ld_ready), 64'd0);
        fetch_one("full_last", 64'hFC, 32'h1000_003F, 1'b0);
        tick();

        // asynchronous reset mid-load
        reload = 1'b1;
        tick();
        reload = 1'b0;
        for (int i = 0; i < 3; i++) load_word(32'hA0 + 32'(i), 1'b0);
        check_eq("arst_pre_count", 64'(count), 64'd3);
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD;
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_ldready", 64'(ld_ready), 64'd1);
        check_eq("arst_loaded", 64'(loaded), 64'd0);
        check_eq("arst_rspvalid", 64'(rsp_valid), 64'd0);
        check_eq("arst_instr", 64'(rsp_instr), 64'd0);
        ld_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_eq("arst_rel_count", 64'(count), 64'd0);
        check_eq("arst_rel_ldready", 64'(ld_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
